// File: rtl/irq_cfg_arbiter_if.sv
// Bundle of requester and router-config signals for irq_cfg_arbiter.
// The slave modport is the arbiter's view. The master modport is the view
// of the environment driving requests and returning router read data.
interface irq_cfg_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      cfg_wr_en;
    logic                      cfg_rd_en;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [DATA_W-1:0]         cfg_wdata;
    logic [DATA_W-1:0]         cfg_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, cfg_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, cfg_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata
    );
endinterface

// File: rtl/irq_cfg_arbiter.sv
// Round-robin arbiter that serialises config reads and writes from NUM_REQ
// requesters onto the single IRQ router config port. One command is in
// flight at a time. Addresses and data pass through untouched.
//
// state  | meaning
// IDLE   | waiting for a request; grant and req_ready are combinational
// ISSUE  | one-cycle write or read strobe carrying the latched command
// RDWAIT | read only: router data is valid; captured at end of cycle
// RESP   | one-cycle rsp_valid pulse to the granted requester
module irq_cfg_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input logic              clk,
    input logic              rst_n,
    irq_cfg_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_q;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic [SUM_W-1:0]   sum;
    logic               grant_found;
    logic               accept;
    logic               cfg_wr_en_q;
    logic               cfg_rd_en_q;
    logic [ADDR_W-1:0]  cfg_addr_q;
    logic [DATA_W-1:0]  cfg_wdata_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [NUM_REQ-1:0] rsp_valid_c;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // req_ready must stay low while reset is held, even though IDLE is forced.
    assign accept = (state == S_IDLE) && grant_found && !rst_n;

    // State register; reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: writes skip RDWAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (grant_found) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = cfg_wr_en_q ? S_RESP : S_RDWAIT;
            S_RDWAIT: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // One-hot accept and completion pulses.
    always_comb begin
        req_ready_c = '0;
        rsp_valid_c = '0;
        if (accept) begin
            req_ready_c[grant_idx] = 1'b1;
        end
        if (state == S_RESP) begin
            rsp_valid_c[gnt_q] = 1'b1;
        end
    end

    // Command latch, registered strobes, pointer update and read capture.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_ptr      <= '0;
            gnt_q       <= '0;
            cfg_wr_en_q <= 1'b0;
            cfg_rd_en_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            cfg_wr_en_q <= 1'b0;
            cfg_rd_en_q <= 1'b0;
            if (accept) begin
                gnt_q       <= grant_idx;
                cfg_wr_en_q <= bus.req_we[grant_idx];
                cfg_rd_en_q <= !bus.req_we[grant_idx];
                cfg_addr_q  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                cfg_wdata_q <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
                if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + PTR_W'(1);
                end
            end
            if (state == S_RDWAIT) begin
                rsp_rdata_q <= bus.cfg_rdata;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.cfg_wr_en = cfg_wr_en_q;
    assign bus.cfg_rd_en = cfg_rd_en_q;
    assign bus.cfg_addr  = cfg_addr_q;
    assign bus.cfg_wdata = cfg_wdata_q;
endmodule

// File: tb/tb_irq_cfg_arbiter.sv
// Self-checking bench for irq_cfg_arbiter: directed scenarios plus a
// randomized run against a transaction-timeline reference model.
module tb_irq_cfg_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    irq_cfg_arbiter_if #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) bus2 ();
    irq_cfg_arbiter_if #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    irq_cfg_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );
    irq_cfg_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    always #5 clk = ~clk;

    // Router stand-in: read data appears the cycle after cfg_rd_en, junk otherwise.
    function automatic logic [DW-1:0] router_val(input logic [AW-1:0] a);
        if (a == 8'h06) return 32'h0000_0085;
        return {a ^ 8'hC3, ~a, a, 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (bus2.cfg_rd_en) bus2.cfg_rdata <= router_val(bus2.cfg_addr);
        else                bus2.cfg_rdata <= $urandom;
    end

    task automatic drive2(input int i, input bit v, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus2.req_valid[i]            = v;
        bus2.req_we[i]               = we;
        bus2.req_addr[i*AW +: AW]    = a;
        bus2.req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic clear_all();
        drive2(0, 1'b0, 1'b0, '0, '0);
        drive2(1, 1'b0, 1'b0, '0, '0);
        bus3.req_valid = '0;
        bus3.req_we    = '0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
    endtask

    task automatic test_reset();
        drive2(0, 1'b1, 1'b1, 8'h11, 32'h1);
        drive2(1, 1'b1, 1'b0, 8'h22, 32'h2);
        bus3.req_valid = 3'b111;
        repeat (2) begin
            @(negedge clk); #1;
            total++; if (bus2.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", bus2.req_ready); end
            total++; if (bus3.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready3: got %b want 000", bus3.req_ready); end
            total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", bus2.rsp_valid); end
            total++; if (bus2.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", bus2.rsp_rdata); end
            total++; if (bus2.cfg_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", bus2.cfg_wr_en); end
            total++; if (bus2.cfg_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus2.cfg_rd_en); end
            total++; if (bus2.cfg_addr !== 8'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus2.cfg_addr); end
            total++; if (bus2.cfg_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bus2.cfg_wdata); end
        end
        @(negedge clk);
        clear_all();
        rst_n = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        drive2(0, 1'b1, 1'b1, 8'h00, 32'h80); #1;
        total++; if (bus2.req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready: got %b want 01", bus2.req_ready); end
        @(negedge clk);
        drive2(0, 1'b0, 1'b0, 8'h00, 32'h0); #1;
        total++; if (bus2.cfg_wr_en !== 1'b1) begin bad++; $display("FAIL wr_strobe: got %b want 1", bus2.cfg_wr_en); end
        total++; if (bus2.cfg_rd_en !== 1'b0) begin bad++; $display("FAIL wr_no_rd: got %b want 0", bus2.cfg_rd_en); end
        total++; if (bus2.cfg_addr !== 8'h00) begin bad++; $display("FAIL wr_addr: got %h want 00", bus2.cfg_addr); end
        total++; if (bus2.cfg_wdata !== 32'h80) begin bad++; $display("FAIL wr_wdata: got %h want 80", bus2.cfg_wdata); end
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_early: got %b want 00", bus2.rsp_valid); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b01) begin bad++; $display("FAIL wr_rsp: got %b want 01", bus2.rsp_valid); end
        total++; if (bus2.cfg_wr_en !== 1'b0) begin bad++; $display("FAIL wr_strobe_len: got %b want 0", bus2.cfg_wr_en); end
        total++; if (bus2.cfg_wdata !== 32'h80) begin bad++; $display("FAIL wr_wdata_hold: got %h want 80", bus2.cfg_wdata); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_len: got %b want 00", bus2.rsp_valid); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive2(1, 1'b1, 1'b0, 8'h06, 32'h0); #1;
        total++; if (bus2.req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready: got %b want 10", bus2.req_ready); end
        @(negedge clk);
        drive2(1, 1'b0, 1'b0, 8'h00, 32'h0); #1;
        total++; if (bus2.cfg_rd_en !== 1'b1) begin bad++; $display("FAIL rd_strobe: got %b want 1", bus2.cfg_rd_en); end
        total++; if (bus2.cfg_wr_en !== 1'b0) begin bad++; $display("FAIL rd_no_wr: got %b want 0", bus2.cfg_wr_en); end
        total++; if (bus2.cfg_addr !== 8'h06) begin bad++; $display("FAIL rd_addr: got %h want 06", bus2.cfg_addr); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_rsp_early: got %b want 00", bus2.rsp_valid); end
        total++; if (bus2.cfg_rd_en !== 1'b0) begin bad++; $display("FAIL rd_strobe_len: got %b want 0", bus2.cfg_rd_en); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b10) begin bad++; $display("FAIL rd_rsp: got %b want 10", bus2.rsp_valid); end
        total++; if (bus2.rsp_rdata !== 32'h85) begin bad++; $display("FAIL rd_rdata: got %h want 85", bus2.rsp_rdata); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_rsp_len: got %b want 00", bus2.rsp_valid); end
        total++; if (bus2.rsp_rdata !== 32'h85) begin bad++; $display("FAIL rd_rdata_hold: got %h want 85", bus2.rsp_rdata); end
    endtask

    task automatic test_contention();
        int cnt[2];
        bit adv[2];
        int gseq[$];
        int scyc[$];
        cnt = '{0, 0};
        adv = '{1'b0, 1'b0};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (adv[i]) cnt[i]++;
                adv[i] = 1'b0;
                if (cnt[i] < 4) drive2(i, 1'b1, 1'b1, AW'(64 + i*16 + cnt[i]), DW'(i*256 + cnt[i]));
                else            drive2(i, 1'b0, 1'b0, '0, '0);
            end
            #1;
            total++; if ($countones(bus2.req_ready) > 1) begin bad++; $display("FAIL cont_onehot: got %b want at most one bit", bus2.req_ready); end
            total++; if (bus2.cfg_wr_en && bus2.cfg_rd_en) begin bad++; $display("FAIL cont_double_strobe: got wr=1 rd=1 want not both"); end
            for (int i = 0; i < 2; i++) begin
                if (bus2.req_ready[i]) begin adv[i] = 1'b1; gseq.push_back(i); end
            end
            if (bus2.cfg_wr_en) scyc.push_back(c);
        end
        total++;
        if (gseq.size() != 8) begin
            bad++; $display("FAIL cont_grant_count: got %0d want 8", gseq.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++; if (gseq[k] != k % 2) begin bad++; $display("FAIL cont_order[%0d]: got %0d want %0d", k, gseq[k], k % 2); end
            end
        end
        total++;
        if (scyc.size() != 8) begin
            bad++; $display("FAIL cont_strobe_count: got %0d want 8", scyc.size());
        end else begin
            for (int k = 1; k < 8; k++) begin
                total++; if (scyc[k] - scyc[k-1] != 3) begin bad++; $display("FAIL cont_spacing[%0d]: got %0d want 3", k, scyc[k] - scyc[k-1]); end
            end
        end
    endtask

    task automatic test_fairness_wrap();
        int gseq[$];
        int exp_order[4];
        exp_order = '{0, 1, 2, 0};
        bus3.req_we    = 3'b111;
        bus3.req_addr  = 24'h030201;
        bus3.req_wdata = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus3.req_valid = (gseq.size() < 4) ? 3'b111 : 3'b000;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (bus3.req_ready[i]) gseq.push_back(i);
            end
        end
        clear_all();
        total++;
        if (gseq.size() != 4) begin
            bad++; $display("FAIL fair_grant_count: got %0d want 4", gseq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++; if (gseq[k] != exp_order[k]) begin bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, gseq[k], exp_order[k]); end
            end
        end
    endtask

    task automatic test_reset_rdwait();
        @(negedge clk);
        drive2(0, 1'b1, 1'b0, 8'h33, 32'h0); #1;
        total++; if (bus2.req_ready !== 2'b01) begin bad++; $display("FAIL rst_rd_ready: got %b want 01", bus2.req_ready); end
        @(negedge clk);
        drive2(0, 1'b0, 1'b0, '0, '0); #1;
        total++; if (bus2.cfg_rd_en !== 1'b1) begin bad++; $display("FAIL rst_rd_strobe: got %b want 1", bus2.cfg_rd_en); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        drive2(0, 1'b1, 1'b1, 8'h44, 32'hCAFE);
        drive2(1, 1'b1, 1'b1, 8'h55, 32'hBEEF);
        repeat (2) begin
            @(negedge clk); #1;
            total++; if (bus2.req_ready !== 2'b00) begin bad++; $display("FAIL rst_mid_ready: got %b want 00", bus2.req_ready); end
            total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_mid_rsp: got %b want 00", bus2.rsp_valid); end
            total++; if (bus2.cfg_rd_en !== 1'b0 || bus2.cfg_wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_strobe: got wr=%b rd=%b want 0 0", bus2.cfg_wr_en, bus2.cfg_rd_en); end
            total++; if (bus2.cfg_addr !== 8'h0 || bus2.cfg_wdata !== 32'h0) begin bad++; $display("FAIL rst_mid_bus: got %h/%h want 0/0", bus2.cfg_addr, bus2.cfg_wdata); end
            total++; if (bus2.rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata: got %h want 0", bus2.rsp_rdata); end
        end
        @(negedge clk);
        rst_n = 1'b0; #1;
        total++; if (bus2.req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant: got %b want 01", bus2.req_ready); end
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_stale_rsp: got %b want 00", bus2.rsp_valid); end
        @(negedge clk);
        clear_all(); #1;
        total++; if (bus2.cfg_wr_en !== 1'b1 || bus2.cfg_rd_en !== 1'b0) begin bad++; $display("FAIL rst_post_strobe: got wr=%b rd=%b want 1 0", bus2.cfg_wr_en, bus2.cfg_rd_en); end
        total++; if (bus2.cfg_addr !== 8'h44) begin bad++; $display("FAIL rst_post_addr: got %h want 44", bus2.cfg_addr); end
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_post_rsp_early: got %b want 00", bus2.rsp_valid); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b01) begin bad++; $display("FAIL rst_post_rsp: got %b want 01", bus2.rsp_valid); end
        total++; if (bus2.rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_post_rdata: got %h want 0", bus2.rsp_rdata); end
        @(negedge clk); #1;
        total++; if (bus2.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_post_rsp_len: got %b want 00", bus2.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [1:0] e_ready, e_rsp;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive2(1, 1'b1, 1'b1, AW'(128 + n), DW'(32'hB000 + n));
            drive2(0, 1'b0, 1'b0, '0, '0);
            #1;
            e_ready = (c % 3 == 0) ? 2'b10 : 2'b00;
            e_rsp   = (c % 3 == 2) ? 2'b10 : 2'b00;
            total++; if (bus2.req_ready !== e_ready) begin bad++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, bus2.req_ready, e_ready); end
            total++; if (bus2.rsp_valid !== e_rsp) begin bad++; $display("FAIL b2b_rsp c=%0d: got %b want %b", c, bus2.rsp_valid, e_rsp); end
            if (c % 3 == 1) begin
                total++; if (bus2.cfg_wr_en !== 1'b1 || bus2.cfg_addr !== AW'(128 + n - 1)) begin bad++; $display("FAIL b2b_strobe c=%0d: got en=%b addr=%h want 1 %h", c, bus2.cfg_wr_en, bus2.cfg_addr, AW'(128 + n - 1)); end
            end
            if (c % 3 == 0) n++;
        end
        @(negedge clk);
        clear_all();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit pend[2];
        bit gnt_prev[2];
        bit cmd_we[2];
        logic [AW-1:0] cmd_addr[2];
        logic [DW-1:0] cmd_data[2];
        int model_rr, free_at, t_acc, t_g, idx;
        bit t_we;
        logic [AW-1:0] t_addr, last_addr;
        logic [DW-1:0] t_data, last_wdata, hold;
        logic [1:0] e_ready, e_rsp;
        bit e_wr, e_rd;

        @(negedge clk);
        clear_all();
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_rr = 0; free_at = 0; t_acc = -100; t_g = 0; t_we = 1'b1;
        t_addr = '0; t_data = '0; last_addr = '0; last_wdata = '0; hold = '0;
        pend = '{1'b0, 1'b0}; gnt_prev = '{1'b0, 1'b0}; cmd_we = '{1'b0, 1'b0};
        cmd_addr = '{'0, '0}; cmd_data = '{'0, '0};

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (gnt_prev[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    cmd_we[i]   = 1'($urandom_range(0, 1));
                    cmd_addr[i] = AW'($urandom);
                    cmd_data[i] = $urandom;
                end
                drive2(i, pend[i], cmd_we[i], cmd_addr[i], cmd_data[i]);
            end
            #1;
            // timeline of the command in flight, relative to its accept cycle
            e_wr = (c == t_acc + 1) && t_we;
            e_rd = (c == t_acc + 1) && !t_we;
            if (c == t_acc + 1) begin last_addr = t_addr; last_wdata = t_data; end
            e_rsp = 2'b00;
            if (c == t_acc + (t_we ? 2 : 3)) begin
                e_rsp[t_g] = 1'b1;
                if (!t_we) hold = router_val(t_addr);
            end
            e_ready  = 2'b00;
            gnt_prev = '{1'b0, 1'b0};
            if (c >= free_at) begin
                for (int k = 0; k < 2; k++) begin
                    idx = (model_rr + k) % 2;
                    if (e_ready == 2'b00 && pend[idx]) begin
                        e_ready[idx]  = 1'b1;
                        gnt_prev[idx] = 1'b1;
                        t_acc    = c;
                        t_g      = idx;
                        t_we     = cmd_we[idx];
                        t_addr   = cmd_addr[idx];
                        t_data   = cmd_data[idx];
                        free_at  = c + (t_we ? 3 : 4);
                        model_rr = (idx + 1) % 2;
                    end
                end
            end
            total++; if (bus2.req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus2.req_ready, e_ready); end
            total++; if (bus2.rsp_valid !== e_rsp) begin bad++; $display("FAIL rnd_rsp c=%0d: got %b want %b", c, bus2.rsp_valid, e_rsp); end
            total++; if (bus2.cfg_wr_en !== e_wr) begin bad++; $display("FAIL rnd_wr c=%0d: got %b want %b", c, bus2.cfg_wr_en, e_wr); end
            total++; if (bus2.cfg_rd_en !== e_rd) begin bad++; $display("FAIL rnd_rd c=%0d: got %b want %b", c, bus2.cfg_rd_en, e_rd); end
            total++; if (bus2.cfg_addr !== last_addr) begin bad++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, bus2.cfg_addr, last_addr); end
            total++; if (bus2.cfg_wdata !== last_wdata) begin bad++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, bus2.cfg_wdata, last_wdata); end
            total++; if (bus2.rsp_rdata !== hold) begin bad++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, bus2.rsp_rdata, hold); end
        end
        @(negedge clk);
        clear_all();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_all();
        bus3.cfg_rdata = '0;
        #2 rst_n = 1'b1;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_fairness_wrap();
        test_reset_rdwait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_cfg_arbiter.md
IRQ_CFG_ARBITER -- requirements
Module: irq_cfg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of config requesters (legal 2..4).
REQ-002 SHALL have parameter ADDR_W, default 8, width of the IRQ router config address.
REQ-003 SHALL have parameter DATA_W, default 32, width of the config data.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester command valid.
REQ-007 SHALL have port req_we  input  NUM_REQ  per-requester command type: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i occupies [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata  input  NUM_REQ*DATA_W  flattened write data; same packing as req_addr.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-hot completion pulse.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data, shared by all requesters, qualified by rsp_valid.
REQ-013 SHALL have port cfg_wr_en  output  1  router config write strobe.
REQ-014 SHALL have port cfg_rd_en  output  1  router config read strobe.
REQ-015 SHALL have port cfg_addr  output  ADDR_W  router config address.
REQ-016 SHALL have port cfg_wdata  output  DATA_W  router config write data.
REQ-017 SHALL have port cfg_rdata  input  DATA_W  router read data; valid the cycle after cfg_rd_en.

Function
REQ-018 SHALL run a four-state FSM: IDLE, ISSUE, RDWAIT, RESP.
REQ-019 In IDLE with any req_valid high, SHALL grant the first valid requester at or after rr_ptr (round-robin, wrapping), assert req_ready[g] combinationally that cycle, latch g/we/addr/wdata, and enter ISSUE.
REQ-020 req_ready SHALL be zero in all states other than IDLE and SHALL never have more than one bit set.
REQ-021 On each grant, rr_ptr SHALL become (g+1) mod NUM_REQ; a lone requester SHALL be granted repeatedly without starvation penalty.
REQ-022 ISSUE SHALL last exactly one cycle, driving registered cfg_wr_en=we or cfg_rd_en=!we with cfg_addr/cfg_wdata = latched values; cfg_wr_en and cfg_rd_en SHALL never both be high.
REQ-023 Write: after ISSUE the FSM SHALL go to RESP; read: after ISSUE it SHALL go to RDWAIT, capture cfg_rdata into rsp_rdata at the end of RDWAIT, then go to RESP.
REQ-024 RESP SHALL pulse rsp_valid[g] for exactly one cycle and return to IDLE; rsp_rdata SHALL hold the captured value until the next read capture, and writes SHALL not alter it.
REQ-025 Latency from accept cycle T: strobe at T+1; write rsp_valid at T+2; read rsp_valid at T+3; the next accept SHALL be no earlier than T+3 (write) or T+4 (read).
REQ-026 cfg_addr/cfg_wdata SHALL hold their last values outside ISSUE; strobes SHALL be zero outside ISSUE.
REQ-027 Addresses and data SHALL be passed unchanged, with no range check; decoding belongs to the router.
REQ-028 Requesters SHALL hold req_valid and the command until req_ready; a req_valid dropped before grant SHALL simply not be granted.
REQ-029 A requester re-asserting req_valid in its own RESP cycle SHALL be eligible in the following IDLE cycle.

Reset
REQ-030 While rst_n is high, SHALL force state IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, cfg_wr_en=0, cfg_rd_en=0, cfg_addr=0, cfg_wdata=0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately: no strobe or rsp_valid for it after reset releases.
REQ-032 The first grant after reset SHALL go to the lowest-index valid requester.

Verification
REQ-033 Single write: req0 write addr 0x00 data 0x80 -> req_ready[0] at T, cfg_wr_en=1 with addr 0x00/wdata 0x80 at T+1, rsp_valid=01 at T+2.
REQ-034 Single read: router returns 0x85 for addr 0x06 -> cfg_rd_en at T+1, rsp_valid[1] at T+3 with rsp_rdata=0x85.
REQ-035 Contention: req0 and req1 hold valid for 4 writes each -> grants alternate 0,1,0,1...; strobes spaced 3 cycles apart; never a double strobe.
REQ-036 Fairness wrap (NUM_REQ=3): all three valid -> grant order 0,1,2,0.
REQ-037 Reset during RDWAIT: rst_n high for 2 cycles -> all outputs 0; no rsp_valid after release; next grant goes to the lowest-index valid requester.
REQ-038 Back-to-back same requester: req1 valid continuously alone -> a grant every 3 cycles for writes, with rsp_valid[1] pulsing once per grant.
